// File: rtl/uart_rx_packet_ctrl_if.sv
// Byte-stream input and checked-packet output bundle
// for the UART packet receiver.
interface uart_rx_packet_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_len;
    logic [63:0] pkt_data;
    logic        err_chksum;
    logic        err_len;
    logic        err_timeout;
    logic        err_overrun;
    logic        busy;

    // Source/consumer side
    modport master (
        output rx_data,
        output rx_valid,
        output pkt_ready,
        input  pkt_valid,
        input  pkt_len,
        input  pkt_data,
        input  err_chksum,
        input  err_len,
        input  err_timeout,
        input  err_overrun,
        input  busy
    );

    // Packet controller side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  pkt_ready,
        output pkt_valid,
        output pkt_len,
        output pkt_data,
        output err_chksum,
        output err_len,
        output err_timeout,
        output err_overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx_packet_ctrl.sv
// Frames UART bytes into SOF/len/payload/checksum packets
// and holds each checked packet until the consumer takes it.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SofByte       = 8'hA5,
    parameter int         MaxLen        = 8,
    parameter int         TimeoutCycles = 50000
) (
    input logic                  clk,
    input logic                  rst,
    uart_rx_packet_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } state_t;

    localparam int TW =
        (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TMO_LAST =
        TW'(TimeoutCycles - 1);
    localparam logic [7:0] MAX_LEN = 8'(MaxLen);

    state_t        state;
    logic [3:0]    len_q;
    logic [2:0]    cnt;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic [63:0]   data_q;
    logic          valid_q;
    logic          busy_q;
    logic          e_chk;
    logic          e_len;
    logic          e_tmo;
    logic          e_ovr;

    logic       rx;
    logic [7:0] b;
    logic       active;
    logic       waiting;
    logic       len_ok;
    logic       last;

    assign rx      = bus.rx_valid;
    assign b       = bus.rx_data;
    assign active  = (state == LEN) || (state == PAYLOAD)
                  || (state == CHK);
    assign waiting = active && !rx;
    assign len_ok  = (b != 8'd0) && (b <= MAX_LEN);
    assign last    = ({1'b0, cnt} == (len_q - 4'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            sum     <= '0;
            tmo     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            e_chk   <= 1'b0;
            e_len   <= 1'b0;
            e_tmo   <= 1'b0;
            e_ovr   <= 1'b0;
        end else begin
            e_chk <= 1'b0;
            e_len <= 1'b0;
            e_tmo <= 1'b0;
            e_ovr <= 1'b0;
            // A byte arriving on the expiry cycle wins
            if (waiting && tmo == TMO_LAST) begin
                e_tmo  <= 1'b1;
                tmo    <= '0;
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                if (waiting) begin
                    tmo <= tmo + 1'b1;
                end else if (active) begin
                    tmo <= '0;
                end
                unique case (state)
                    IDLE: begin
                        tmo <= '0;
                        if (rx && b == SofByte) begin
                            state  <= LEN;
                            busy_q <= 1'b1;
                        end
                    end
                    LEN: begin
                        if (rx && len_ok) begin
                            len_q  <= b[3:0];
                            data_q <= '0;
                            sum    <= b;
                            cnt    <= '0;
                            state  <= PAYLOAD;
                        end else if (rx) begin
                            e_len  <= 1'b1;
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    PAYLOAD: begin
                        if (rx) begin
                            data_q[{cnt, 3'b000} +: 8] <= b;
                            sum <= sum + b;
                            cnt <= cnt + 3'd1;
                            if (last) begin
                                state <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        if (rx && b == sum) begin
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end else if (rx) begin
                            e_chk  <= 1'b1;
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    HOLD: begin
                        tmo <= '0;
                        // Packet is frozen; extra bytes are lost
                        if (rx) begin
                            e_ovr <= 1'b1;
                        end
                        if (bus.pkt_ready) begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pkt_valid   = valid_q;
    assign bus.pkt_len     = len_q;
    assign bus.pkt_data    = data_q;
    assign bus.err_chksum  = e_chk;
    assign bus.err_len     = e_len;
    assign bus.err_timeout = e_tmo;
    assign bus.err_overrun = e_ovr;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed checks of packet framing, errors, timeout,
// overrun and reset behaviour.
module tb_uart_rx_packet_ctrl;

    localparam int T = 20;

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;

    uart_rx_packet_ctrl_if bus_if ();

    uart_rx_packet_ctrl #(
        .SofByte      (8'hA5),
        .MaxLen       (8),
        .TimeoutCycles(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] v);
        bus_if.rx_data  = v;
        bus_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'hA5;
        tick(2);
        bus_if.rx_valid = 1'b0;
        rst = 1'b0;
        nvec++;
        if (bus_if.busy !== 1'b0 || bus_if.pkt_valid !== 1'b0) begin
            nmis++;
            $display("FAIL reset_ctl: busy=%b valid=%b want 0 0",
                     bus_if.busy, bus_if.pkt_valid);
        end
        nvec++;
        if (bus_if.pkt_len !== 4'd0 || bus_if.pkt_data !== 64'd0) begin
            nmis++;
            $display("FAIL reset_pkt: len=%h data=%h want 0 0",
                     bus_if.pkt_len, bus_if.pkt_data);
        end
        nvec++;
        if ({bus_if.err_chksum, bus_if.err_len, bus_if.err_timeout,
             bus_if.err_overrun} !== 4'b0000) begin
            nmis++;
            $display("FAIL reset_err: got %b%b%b%b want 0000",
                     bus_if.err_chksum, bus_if.err_len,
                     bus_if.err_timeout, bus_if.err_overrun);
        end
    endtask

    task automatic test_good_packet;
        bus_if.pkt_ready = 1'b1;
        send(8'hA5);
        nvec++;
        if (bus_if.busy !== 1'b1) begin
            nmis++;
            $display("FAIL sof_busy: got %b want 1", bus_if.busy);
        end
        send(8'h03);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        nvec++;
        if (bus_if.pkt_valid !== 1'b0) begin
            nmis++;
            $display("FAIL early_valid: got %b want 0",
                     bus_if.pkt_valid);
        end
        send(8'h69);
        nvec++;
        if (bus_if.pkt_valid !== 1'b1) begin
            nmis++;
            $display("FAIL good_valid: got %b want 1",
                     bus_if.pkt_valid);
        end
        nvec++;
        if (bus_if.pkt_len !== 4'd3) begin
            nmis++;
            $display("FAIL good_len: got %0d want 3", bus_if.pkt_len);
        end
        nvec++;
        if (bus_if.pkt_data !== 64'h0000000000332211) begin
            nmis++;
            $display("FAIL good_data: got %h want 332211",
                     bus_if.pkt_data);
        end
        tick(1);
        nvec++;
        if (bus_if.pkt_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            nmis++;
            $display("FAIL good_drop: valid=%b busy=%b want 0 0",
                     bus_if.pkt_valid, bus_if.busy);
        end
    endtask

    task automatic test_bad_chksum;
        bus_if.pkt_ready = 1'b1;
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h6A);
        nvec++;
        if (bus_if.err_chksum !== 1'b1 || bus_if.pkt_valid !== 1'b0) begin
            nmis++;
            $display("FAIL chk_pulse: err=%b valid=%b want 1 0",
                     bus_if.err_chksum, bus_if.pkt_valid);
        end
        nvec++;
        if (bus_if.busy !== 1'b0) begin
            nmis++;
            $display("FAIL chk_busy: got %b want 0", bus_if.busy);
        end
        tick(1);
        nvec++;
        if (bus_if.err_chksum !== 1'b0 || bus_if.pkt_valid !== 1'b0) begin
            nmis++;
            $display("FAIL chk_after: err=%b valid=%b want 0 0",
                     bus_if.err_chksum, bus_if.pkt_valid);
        end
    endtask

    task automatic test_bad_len;
        bus_if.pkt_ready = 1'b1;
        send(8'hA5);
        send(8'h00);
        nvec++;
        if (bus_if.err_len !== 1'b1 || bus_if.busy !== 1'b0) begin
            nmis++;
            $display("FAIL len0: err=%b busy=%b want 1 0",
                     bus_if.err_len, bus_if.busy);
        end
        tick(1);
        nvec++;
        if (bus_if.err_len !== 1'b0) begin
            nmis++;
            $display("FAIL len_pulse: got %b want 0", bus_if.err_len);
        end
        send(8'hA5);
        send(8'h09);
        nvec++;
        if (bus_if.err_len !== 1'b1) begin
            nmis++;
            $display("FAIL len9: got %b want 1", bus_if.err_len);
        end
        send(8'hA5);
        send(8'h01);
        send(8'hFF);
        send(8'h00);
        nvec++;
        if (bus_if.pkt_valid !== 1'b1 || bus_if.pkt_len !== 4'd1) begin
            nmis++;
            $display("FAIL len1_pkt: valid=%b len=%0d want 1 1",
                     bus_if.pkt_valid, bus_if.pkt_len);
        end
        nvec++;
        if (bus_if.pkt_data !== 64'h00000000000000FF) begin
            nmis++;
            $display("FAIL len1_data: got %h want FF",
                     bus_if.pkt_data);
        end
        tick(1);
    endtask

    task automatic test_timeout;
        bus_if.pkt_ready = 1'b1;
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        tick(T - 1);
        nvec++;
        if (bus_if.err_timeout !== 1'b0 || bus_if.busy !== 1'b1) begin
            nmis++;
            $display("FAIL tmo_early: err=%b busy=%b want 0 1",
                     bus_if.err_timeout, bus_if.busy);
        end
        tick(1);
        nvec++;
        if (bus_if.err_timeout !== 1'b1 || bus_if.busy !== 1'b0) begin
            nmis++;
            $display("FAIL tmo_fire: err=%b busy=%b want 1 0",
                     bus_if.err_timeout, bus_if.busy);
        end
        tick(1);
        nvec++;
        if (bus_if.err_timeout !== 1'b0) begin
            nmis++;
            $display("FAIL tmo_pulse: got %b want 0",
                     bus_if.err_timeout);
        end
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        tick(T - 1);
        send(8'h22);
        nvec++;
        if (bus_if.err_timeout !== 1'b0 || bus_if.busy !== 1'b1) begin
            nmis++;
            $display("FAIL tmo_edge: err=%b busy=%b want 0 1",
                     bus_if.err_timeout, bus_if.busy);
        end
        send(8'h35);
        nvec++;
        if (bus_if.pkt_valid !== 1'b1
            || bus_if.pkt_data !== 64'h0000000000002211) begin
            nmis++;
            $display("FAIL tmo_pkt: valid=%b data=%h want 1 2211",
                     bus_if.pkt_valid, bus_if.pkt_data);
        end
        tick(1);
    endtask

    task automatic test_overrun;
        bus_if.pkt_ready = 1'b0;
        send(8'hA5);
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        send(8'h67);
        tick(T + 5);
        nvec++;
        if (bus_if.pkt_valid !== 1'b1 || bus_if.err_timeout !== 1'b0) begin
            nmis++;
            $display("FAIL hold: valid=%b tmo=%b want 1 0",
                     bus_if.pkt_valid, bus_if.err_timeout);
        end
        send(8'h55);
        nvec++;
        if (bus_if.err_overrun !== 1'b1) begin
            nmis++;
            $display("FAIL ovr_pulse: got %b want 1",
                     bus_if.err_overrun);
        end
        nvec++;
        if (bus_if.pkt_data !== 64'h000000000000BBAA
            || bus_if.pkt_len !== 4'd2) begin
            nmis++;
            $display("FAIL ovr_data: data=%h len=%0d want BBAA 2",
                     bus_if.pkt_data, bus_if.pkt_len);
        end
        tick(1);
        nvec++;
        if (bus_if.err_overrun !== 1'b0 || bus_if.pkt_valid !== 1'b1) begin
            nmis++;
            $display("FAIL ovr_after: err=%b valid=%b want 0 1",
                     bus_if.err_overrun, bus_if.pkt_valid);
        end
        bus_if.pkt_ready = 1'b1;
        send(8'h66);
        nvec++;
        if (bus_if.err_overrun !== 1'b1 || bus_if.pkt_valid !== 1'b0) begin
            nmis++;
            $display("FAIL ovr_hs: err=%b valid=%b want 1 0",
                     bus_if.err_overrun, bus_if.pkt_valid);
        end
        nvec++;
        if (bus_if.busy !== 1'b0 || bus_if.pkt_data !== 64'h000000000000BBAA) begin
            nmis++;
            $display("FAIL ovr_idle: busy=%b data=%h want 0 BBAA",
                     bus_if.busy, bus_if.pkt_data);
        end
        tick(1);
    endtask

    task automatic test_reset_mid;
        bus_if.pkt_ready = 1'b1;
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        rst = 1'b1;
        send(8'hA5);
        rst = 1'b0;
        nvec++;
        if (bus_if.busy !== 1'b0 || bus_if.pkt_len !== 4'd0
            || bus_if.pkt_data !== 64'd0) begin
            nmis++;
            $display("FAIL rst_mid: busy=%b len=%0d data=%h want 0",
                     bus_if.busy, bus_if.pkt_len, bus_if.pkt_data);
        end
        nvec++;
        if ({bus_if.err_chksum, bus_if.err_len, bus_if.err_timeout,
             bus_if.err_overrun, bus_if.pkt_valid} !== 5'b00000) begin
            nmis++;
            $display("FAIL rst_mid_err: got %b%b%b%b%b want 00000",
                     bus_if.err_chksum, bus_if.err_len,
                     bus_if.err_timeout, bus_if.err_overrun,
                     bus_if.pkt_valid);
        end
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h69);
        nvec++;
        if (bus_if.pkt_valid !== 1'b1
            || bus_if.pkt_data !== 64'h0000000000332211) begin
            nmis++;
            $display("FAIL rst_pkt: valid=%b data=%h want 1 332211",
                     bus_if.pkt_valid, bus_if.pkt_data);
        end
        tick(1);
        bus_if.pkt_ready = 1'b0;
        send(8'hA5);
        send(8'h01);
        send(8'h10);
        send(8'h11);
        nvec++;
        if (bus_if.pkt_valid !== 1'b1) begin
            nmis++;
            $display("FAIL hold_pre: got %b want 1", bus_if.pkt_valid);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        nvec++;
        if ({bus_if.pkt_valid, bus_if.busy, bus_if.err_overrun,
             bus_if.err_chksum} !== 4'b0000
            || bus_if.pkt_data !== 64'd0) begin
            nmis++;
            $display("FAIL rst_hold: v/b/ovr/chk=%b%b%b%b data=%h want 0",
                     bus_if.pkt_valid, bus_if.busy,
                     bus_if.err_overrun, bus_if.err_chksum,
                     bus_if.pkt_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nvec = 0;
        nmis = 0;
        rst = 1'b1;
        bus_if.rx_data   = 8'h00;
        bus_if.rx_valid  = 1'b0;
        bus_if.pkt_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_good_packet();
        test_bad_chksum();
        test_bad_len();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

endmodule

// File: doc/uart_rx_packet_ctrl.md
UART_RX_PACKET_CTRL -- requirements
Module: uart_rx_packet_ctrl

Interface
REQ-001 SHALL have parameter SofByte, default 8'hA5, start-of-frame marker.
REQ-002 SHALL have parameter MaxLen, default 8, max payload bytes (1..8).
REQ-003 SHALL have parameter TimeoutCycles, default 50000, max inter-byte gap in clk cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_data  input  8  received byte; valid only while rx_valid=1.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe from the UART receiver.
REQ-008 SHALL have port pkt_valid  output  1  complete, checked packet available.
REQ-009 SHALL have port pkt_ready  input  1  consumer accepts packet.
REQ-010 SHALL have port pkt_len  output  4  payload byte count.
REQ-011 SHALL have port pkt_data  output  64  payload; byte i in bits [8i+7:8i]; unused bytes 0.
REQ-012 SHALL have port err_chksum  output  1  one-cycle pulse, checksum mismatch.
REQ-013 SHALL have port err_len  output  1  one-cycle pulse, illegal length.
REQ-014 SHALL have port err_timeout  output  1  one-cycle pulse, inter-byte gap expired.
REQ-015 SHALL have port err_overrun  output  1  one-cycle pulse, byte dropped while holding a packet.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LEN, PAYLOAD, CHK, HOLD; all outputs registered.
REQ-018 IDLE: rx_valid with rx_data==SofByte -> LEN; other bytes ignored, no error.
REQ-019 LEN: rx_valid with 1<=rx_data<=MaxLen -> store length, clear pkt_data buffer, sum=rx_data, -> PAYLOAD.
REQ-020 LEN: rx_valid with rx_data==0 or >MaxLen -> err_len pulse next cycle, -> IDLE.
REQ-021 PAYLOAD: each rx_valid byte written to byte index = count, sum += byte (mod 256), count increments; on last byte (count==len-1) -> CHK.
REQ-022 CHK: rx_valid with rx_data==sum -> HOLD, pkt_valid=1 on the following cycle; mismatch -> err_chksum pulse, -> IDLE, pkt_valid stays 0.
REQ-023 Latency: pkt_valid rises exactly 1 cycle after the checksum-byte rx_valid cycle.
REQ-024 HOLD: pkt_valid, pkt_len, pkt_data held stable until cycle with pkt_ready=1; pkt_valid low the next cycle, -> IDLE.
REQ-025 HOLD: any rx_valid (including handshake cycle) SHALL be dropped with err_overrun pulse; packet contents unchanged.
REQ-026 Timeout counter SHALL clear on every rx_valid and on entry to LEN; in LEN/PAYLOAD/CHK, reaching TimeoutCycles-1 with no rx_valid -> err_timeout pulse, -> IDLE; counter idle in IDLE/HOLD.
REQ-027 rx_valid on the same cycle the timeout expires SHALL take priority (byte accepted, no timeout).
REQ-028 pkt_len/pkt_data SHALL only change on LEN entry or payload write, never while pkt_valid=1.
REQ-029 Error pulses SHALL be mutually exclusive per cycle and never coincide with pkt_valid rising.

Reset
REQ-030 rst=1 SHALL force IDLE, clear count, sum, timeout counter, pkt_len=0, pkt_data=0, and drive pkt_valid, busy, all err_* to 0 the next cycle.
REQ-031 rst mid-packet or in HOLD SHALL discard the packet without any error pulse.
REQ-032 rx_valid while rst=1 SHALL be ignored.

Verification
REQ-033 Bytes A5 03 11 22 33 69, pkt_ready=1 -> pkt_valid 1 cycle after 69, pkt_len=3, pkt_data=64'h0000000000332211, one cycle wide.
REQ-034 Bytes A5 03 11 22 33 6A -> err_chksum pulse, pkt_valid never asserts, busy returns 0.
REQ-035 Bytes A5 00 and A5 09 -> err_len pulse each; next A5 01 FF 00 -> valid packet len=1, data=FF.
REQ-036 A5 02 11 then silence TimeoutCycles cycles -> err_timeout pulse, IDLE; byte at cycle TimeoutCycles-1 instead -> accepted, no timeout.
REQ-037 Valid packet with pkt_ready=0, then byte 55 -> err_overrun, pkt_data unchanged; pkt_ready=1 -> pkt_valid drops next cycle.
REQ-038 rst asserted after A5 03 11 -> all outputs 0; then full valid packet -> accepted normally.
